// File: rtl/set_arbiter_pkg.sv
// Shared types and constants for the set-engine arbiter.
package set_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_A    = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam int CENTRAL_W   = 24;
  localparam int RADIUS_W    = 12;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/set_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [N-1:0] rot;
  logic [PW:0]  sum;

  // Rotate so that bit 0 of rot is requester ptr.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (PW + 1)'(k);
      end
    end
  end

  assign idx = (sum >= (PW + 1)'(N)) ? PW'(sum - (PW + 1)'(N)) : PW'(sum);

endmodule

// File: rtl/set_arbiter.sv
// Round-robin arbiter sharing one set-counting engine among N_REQ requesters,
// with operand latching, a single outstanding job and a watchdog abort.
module set_arbiter
  import set_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [CENTRAL_W*N_REQ-1:0] req_central,
  input  logic [RADIUS_W*N_REQ-1:0]  req_radius,
  input  logic [2*N_REQ-1:0]         req_mode,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic [7:0]                 result,
  output logic                       err,
  output logic                       set_en,
  output logic [CENTRAL_W-1:0]       set_central,
  output logic [RADIUS_W-1:0]        set_radius,
  output logic [1:0]                 set_mode,
  input  logic                       set_valid,
  input  logic [7:0]                 set_candidate
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cur;
  logic [7:0]      cnt;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] cur_oh;
  logic [1:0]      win_mode;

  logic [CENTRAL_W-1:0] cen_a  [N_REQ];
  logic [RADIUS_W-1:0]  rad_a  [N_REQ];
  logic [1:0]           mode_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign cen_a[i]  = req_central[i*CENTRAL_W +: CENTRAL_W];
    assign rad_a[i]  = req_radius[i*RADIUS_W +: RADIUS_W];
    assign mode_a[i] = req_mode[i*2 +: 2];
  end

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign win_mode = mode_a[pick_idx];
  assign pick_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign cur_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cur         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      result      <= '0;
      err         <= 1'b0;
      set_en      <= 1'b0;
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
    end else begin
      gnt    <= '0;
      done   <= '0;
      set_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            cur         <= pick_idx;
            ptr         <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
            set_central <= cen_a[pick_idx];
            set_radius  <= rad_a[pick_idx];
            set_mode    <= win_mode;
            gnt         <= pick_oh;
            // Reserved mode never reaches the engine: answer with an error directly.
            if (win_mode == MODE_RSVD) begin
              result <= '0;
              err    <= 1'b1;
              done   <= pick_oh;
              state  <= ST_RESP;
            end else begin
              set_en <= 1'b1;
              state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (set_valid) begin
            result <= set_candidate;
            err    <= 1'b0;
            done   <= cur_oh;
            state  <= ST_RESP;
          end else if (cnt + 8'd1 == 8'(TIMEOUT)) begin
            result <= '0;
            err    <= 1'b1;
            done   <= cur_oh;
            state  <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
